// File: rtl/rfile_wb_arb.sv
// Two-requester register-file writeback arbiter (ALU = A, load = B), round-robin or A-priority.
// Latency: one cycle from accepted request to registered regWrite/writeR/writeRData.
// Backpressure: wr_stall or a lost arbitration holds ready low; requester keeps valid/reg/data stable.
//
// Ports:
//   clk, rst (async, active-low)
//   a_valid/a_reg/a_data/a_ready : requester A (ALU writeback)
//   b_valid/b_reg/b_data/b_ready : requester B (load writeback)
//   wr_stall                     : write port unavailable, blocks all grants
//   regWrite/writeR/writeRData   : registered write port toward the register file
//   wr_count                     : committed writes (wraps), x0_drops: accepted writes to r0 (saturates)
module rfile_wb_arb #(
    parameter int MODE = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        a_valid,
    input  logic [4:0]  a_reg,
    input  logic [31:0] a_data,
    output logic        a_ready,
    input  logic        b_valid,
    input  logic [4:0]  b_reg,
    input  logic [31:0] b_data,
    output logic        b_ready,
    input  logic        wr_stall,
    output logic        regWrite,
    output logic [4:0]  writeR,
    output logic [31:0] writeRData,
    output logic [15:0] wr_count,
    output logic [7:0]  x0_drops
);

    localparam logic GRANT_A   = 1'b0;
    localparam logic GRANT_B   = 1'b1;
    localparam logic FIXED_PRI = (MODE == 1);

    logic        last_grant;
    logic        a_wins_tie;
    logic        a_xfer;
    logic        b_xfer;
    logic        xfer;
    logic [4:0]  sel_reg;
    logic [31:0] sel_data;
    logic        sel_is_x0;

    // On contention A wins under fixed priority, or in round-robin when B had the last grant.
    assign a_wins_tie = FIXED_PRI | (last_grant == GRANT_B);

    // Ready is gated by rst so nothing is accepted while reset is held.
    assign a_ready = rst & ~wr_stall & a_valid & (~b_valid | a_wins_tie);
    assign b_ready = rst & ~wr_stall & b_valid & ~(a_valid & a_wins_tie);

    assign a_xfer    = a_valid & a_ready;
    assign b_xfer    = b_valid & b_ready;
    assign xfer      = a_xfer | b_xfer;
    assign sel_reg   = a_xfer ? a_reg  : b_reg;
    assign sel_data  = a_xfer ? a_data : b_data;
    assign sel_is_x0 = (sel_reg == 5'd0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_grant <= GRANT_B;
            regWrite   <= 1'b0;
            writeR     <= 5'd0;
            writeRData <= 32'd0;
            wr_count   <= 16'd0;
            x0_drops   <= 8'd0;
        end else begin
            regWrite <= xfer & ~sel_is_x0;
            if (xfer) begin
                last_grant <= b_xfer ? GRANT_B : GRANT_A;
                if (!sel_is_x0) begin
                    // Count is bumped alongside regWrite so it already reflects the visible write.
                    writeR     <= sel_reg;
                    writeRData <= sel_data;
                    wr_count   <= wr_count + 16'd1;
                end else if (x0_drops != 8'hFF) begin
                    // r0 writes are swallowed: port keeps its previous address/data.
                    x0_drops <= x0_drops + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_rfile_wb_arb.sv
// Bench for rfile_wb_arb: DUT 0 round-robin, DUT 1 fixed priority, checked against a
// transaction-level model each negedge, plus directed literal scenarios.
module tb_rfile_wb_arb;

    logic        clk;
    logic        rst;
    logic        av [2];
    logic [4:0]  ar [2];
    logic [31:0] ad [2];
    logic        bv [2];
    logic [4:0]  br [2];
    logic [31:0] bd [2];
    logic        st [2];
    logic        rdya [2];
    logic        rdyb [2];
    logic        rw   [2];
    logic [4:0]  wr_r [2];
    logic [31:0] wr_d [2];
    logic [15:0] cnt  [2];
    logic [7:0]  x0   [2];

    int tests = 0;
    int fails = 0;

    rfile_wb_arb #(.MODE(0)) dut0 (
        .clk(clk), .rst(rst),
        .a_valid(av[0]), .a_reg(ar[0]), .a_data(ad[0]), .a_ready(rdya[0]),
        .b_valid(bv[0]), .b_reg(br[0]), .b_data(bd[0]), .b_ready(rdyb[0]),
        .wr_stall(st[0]), .regWrite(rw[0]), .writeR(wr_r[0]), .writeRData(wr_d[0]),
        .wr_count(cnt[0]), .x0_drops(x0[0])
    );

    rfile_wb_arb #(.MODE(1)) dut1 (
        .clk(clk), .rst(rst),
        .a_valid(av[1]), .a_reg(ar[1]), .a_data(ad[1]), .a_ready(rdya[1]),
        .b_valid(bv[1]), .b_reg(br[1]), .b_data(bd[1]), .b_ready(rdyb[1]),
        .wr_stall(st[1]), .regWrite(rw[1]), .writeR(wr_r[1]), .writeRData(wr_d[1]),
        .wr_count(cnt[1]), .x0_drops(x0[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic        m_last_b [2];   // 1: B was granted most recently
    logic        m_we     [2];
    logic [4:0]  m_wr     [2];
    logic [31:0] m_wd     [2];
    int          m_cnt    [2];
    int          m_x0     [2];
    logic        xa [2];
    logic        xb [2];
    int          wait_a, wait_b;

    function automatic void model_reset();
        for (int d = 0; d < 2; d++) begin
            m_last_b[d] = 1'b1;
            m_we[d] = 1'b0; m_wr[d] = 5'd0; m_wd[d] = 32'd0;
            m_cnt[d] = 0; m_x0[d] = 0;
            xa[d] = 1'b0; xb[d] = 1'b0;
        end
        wait_a = 0; wait_b = 0;
    endfunction

    // {b_granted, a_granted}; DUT 1 is the fixed-priority instance.
    function automatic logic [1:0] grant(input int d);
        if (!rst || st[d]) return 2'b00;
        if (av[d] && bv[d]) begin
            if (d == 1) return 2'b01;
            return m_last_b[d] ? 2'b01 : 2'b10;
        end
        return {bv[d], av[d]};
    endfunction

    function automatic void take(input int d, input logic [4:0] r, input logic [31:0] dat, input logic is_b);
        m_last_b[d] = is_b;
        if (r == 5'd0) begin
            m_we[d] = 1'b0;
            if (m_x0[d] < 255) m_x0[d] = m_x0[d] + 1;
        end else begin
            m_we[d] = 1'b1;
            m_wr[d] = r;
            m_wd[d] = dat;
            m_cnt[d] = (m_cnt[d] + 1) % 65536;
        end
    endfunction

    always @(negedge rst) model_reset();

    always @(posedge clk) begin : model_step
        logic [1:0] g;
        if (rst) begin
            for (int d = 0; d < 2; d++) begin
                g = grant(d);
                xa[d] = g[0];
                xb[d] = g[1];
                if (d == 0) begin
                    // round-robin fairness: a held requester loses at most one grant
                    if (xa[0]) begin
                        chk("rr_wait_a", 32'(wait_a <= 1), 32'd1);
                        wait_a = 0;
                    end else if (av[0] && xb[0]) wait_a++;
                    if (xb[0]) begin
                        chk("rr_wait_b", 32'(wait_b <= 1), 32'd1);
                        wait_b = 0;
                    end else if (bv[0] && xa[0]) wait_b++;
                end
                if (g[0])      take(d, ar[d], ad[d], 1'b0);
                else if (g[1]) take(d, br[d], bd[d], 1'b1);
                else           m_we[d] = 1'b0;
            end
        end
    end

    always @(negedge clk) begin : compare
        logic [1:0] g;
        for (int d = 0; d < 2; d++) begin
            g = grant(d);
            chk($sformatf("a_ready[%0d]", d),    32'(rdya[d]), 32'(g[0]));
            chk($sformatf("b_ready[%0d]", d),    32'(rdyb[d]), 32'(g[1]));
            chk($sformatf("regWrite[%0d]", d),   32'(rw[d]),   32'(m_we[d]));
            chk($sformatf("writeR[%0d]", d),     32'(wr_r[d]), 32'(m_wr[d]));
            chk($sformatf("writeRData[%0d]", d), wr_d[d],      m_wd[d]);
            chk($sformatf("wr_count[%0d]", d),   32'(cnt[d]),  32'(m_cnt[d][15:0]));
            chk($sformatf("x0_drops[%0d]", d),   32'(x0[d]),   32'(m_x0[d]));
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_a(input int d, input logic v, input logic [4:0] r, input logic [31:0] dat);
        av[d] = v; ar[d] = r; ad[d] = dat;
    endtask

    task automatic set_b(input int d, input logic v, input logic [4:0] r, input logic [31:0] dat);
        bv[d] = v; br[d] = r; bd[d] = dat;
    endtask

    initial begin
        model_reset();
        rst = 1'b0;
        for (int d = 0; d < 2; d++) begin
            set_a(d, 1'b0, 5'd0, 32'd0);
            set_b(d, 1'b0, 5'd0, 32'd0);
            st[d] = 1'b0;
        end
        #2;
        chk("reset_regWrite", 32'(rw[0]), 32'd0);
        chk("reset_wr_count", 32'(cnt[0]), 32'd0);
        step(); step();
        rst = 1'b1;
        step();

        // single A write
        set_a(0, 1'b1, 5'd5, 32'hDEADBEEF);
        #1 chk("single_a_ready", 32'(rdya[0]), 32'd1);
        step();
        set_a(0, 1'b0, 5'd0, 32'd0);
        chk("single_regWrite", 32'(rw[0]), 32'd1);
        chk("single_writeR", 32'(wr_r[0]), 32'd5);
        chk("single_writeRData", wr_d[0], 32'hDEADBEEF);
        chk("single_wr_count", 32'(cnt[0]), 32'd1);
        step();
        chk("idle_regWrite", 32'(rw[0]), 32'd0);
        chk("idle_writeR_hold", 32'(wr_r[0]), 32'd5);

        // writes to r0: accepted but dropped, drop counter saturates
        set_a(0, 1'b1, 5'd0, 32'hFFFFFFFF);
        #1 chk("x0_a_ready", 32'(rdya[0]), 32'd1);
        step();
        chk("x0_regWrite", 32'(rw[0]), 32'd0);
        chk("x0_drops_1", 32'(x0[0]), 32'd1);
        chk("x0_wr_count", 32'(cnt[0]), 32'd1);
        for (int i = 0; i < 299; i++) step();
        set_a(0, 1'b0, 5'd0, 32'd0);
        chk("x0_drops_sat", 32'(x0[0]), 32'hFF);
        chk("x0_wr_count_after", 32'(cnt[0]), 32'd1);

        // stall holds off a pending write
        st[0] = 1'b1;
        set_a(0, 1'b1, 5'd7, 32'hCAFE0007);
        for (int i = 0; i < 3; i++) begin
            #1 chk("stall_a_ready", 32'(rdya[0]), 32'd0);
            step();
            chk("stall_regWrite", 32'(rw[0]), 32'd0);
        end
        st[0] = 1'b0;
        #1 chk("unstall_a_ready", 32'(rdya[0]), 32'd1);
        step();
        set_a(0, 1'b0, 5'd0, 32'd0);
        chk("unstall_regWrite", 32'(rw[0]), 32'd1);
        chk("unstall_writeR", 32'(wr_r[0]), 32'd7);
        chk("unstall_wr_count", 32'(cnt[0]), 32'd2);
        step();

        // async reset right after a transfer
        set_a(0, 1'b1, 5'd3, 32'h33);
        step();
        set_a(0, 1'b1, 5'd4, 32'h44);
        set_b(0, 1'b1, 5'd5, 32'h55);
        #2 rst = 1'b0;
        #1;
        chk("arst_regWrite", 32'(rw[0]), 32'd0);
        chk("arst_wr_count", 32'(cnt[0]), 32'd0);
        chk("arst_x0_drops", 32'(x0[0]), 32'd0);
        chk("arst_a_ready", 32'(rdya[0]), 32'd0);
        chk("arst_b_ready", 32'(rdyb[0]), 32'd0);
        #3 rst = 1'b1;
        #1;
        chk("post_rst_a_ready", 32'(rdya[0]), 32'd1);
        chk("post_rst_b_ready", 32'(rdyb[0]), 32'd0);
        step();
        set_a(0, 1'b0, 5'd0, 32'd0);
        chk("post_rst_writeR", 32'(wr_r[0]), 32'd4);
        step();
        set_b(0, 1'b0, 5'd0, 32'd0);
        chk("post_rst_b_writeR", 32'(wr_r[0]), 32'd5);
        chk("post_rst_wr_count", 32'(cnt[0]), 32'd2);

        // round-robin contention: A,B,A,B
        set_a(0, 1'b1, 5'd1, 32'h11);
        set_b(0, 1'b1, 5'd2, 32'h22);
        for (int i = 0; i < 4; i++) begin
            logic [31:0] exp_d [4];
            exp_d[0] = 32'h11; exp_d[1] = 32'h22; exp_d[2] = 32'h111; exp_d[3] = 32'h222;
            #1;
            chk("rr_a_ready", 32'(rdya[0]), 32'(i % 2 == 0));
            chk("rr_b_ready", 32'(rdyb[0]), 32'(i % 2 == 1));
            step();
            if (i % 2 == 0) ad[0] = 32'h111; else bd[0] = 32'h222;
            chk("rr_regWrite", 32'(rw[0]), 32'd1);
            chk("rr_writeR", 32'(wr_r[0]), (i % 2 == 0) ? 32'd1 : 32'd2);
            chk("rr_writeRData", wr_d[0], exp_d[i]);
        end
        set_a(0, 1'b0, 5'd0, 32'd0);
        set_b(0, 1'b0, 5'd0, 32'd0);
        chk("rr_wr_count", 32'(cnt[0]), 32'd6);

        // fixed priority on DUT 1
        set_a(1, 1'b1, 5'd8, 32'h80);
        set_b(1, 1'b1, 5'd9, 32'h99);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("fp_a_ready", 32'(rdya[1]), 32'd1);
            chk("fp_b_ready", 32'(rdyb[1]), 32'd0);
            step();
            ad[1] = 32'h81 + 32'(i);
            chk("fp_writeR", 32'(wr_r[1]), 32'd8);
        end
        av[1] = 1'b0;
        #1 chk("fp_b_ready_after", 32'(rdyb[1]), 32'd1);
        step();
        set_b(1, 1'b0, 5'd0, 32'd0);
        chk("fp_b_writeR", 32'(wr_r[1]), 32'd9);
        chk("fp_b_writeRData", wr_d[1], 32'h99);

        // randomized traffic on both instances, checked by the model
        for (int c = 0; c < 3000; c++) begin
            for (int d = 0; d < 2; d++) begin
                if (!av[d] || xa[d])
                    set_a(d, $urandom_range(0, 2) != 0, 5'($urandom_range(0, 31)), $urandom);
                if (!bv[d] || xb[d])
                    set_b(d, $urandom_range(0, 2) != 0, 5'($urandom_range(0, 31)), $urandom);
                st[d] = ($urandom_range(0, 3) == 0);
            end
            if (c == 1500) begin
                #2 rst = 1'b0;
                step(); step();
                rst = 1'b1;
            end
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/rfile_wb_arb.md
RFILE_WB_ARB -- requirements
Module: rfile_wb_arb

Interface
REQ-001 Parameter: MODE, 0, arbitration policy (0 = round-robin, 1 = fixed priority, requester A wins).
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous reset, active-low (0 = reset asserted).
REQ-004 a_valid  input  1  requester A (ALU writeback) has a write pending.
REQ-005 a_reg  input  5  destination register for A.
REQ-006 a_data  input  32  write data for A.
REQ-007 a_ready  output  1  A's write accepted this cycle when a_valid is also high.
REQ-008 b_valid, b_reg, b_data, b_ready: same widths and meanings as REQ-004..007, for requester B (load writeback).
REQ-009 wr_stall  input  1  register file write port unavailable this cycle.
REQ-010 regWrite  output  1  registered write enable to the register file.
REQ-011 writeR  output  5  registered write address.
REQ-012 writeRData  output  32  registered write data.
REQ-013 wr_count  output  16  count of committed writes (regWrite pulses).
REQ-014 x0_drops  output  8  count of accepted writes targeting register 0.

Function
REQ-015 Handshake: a transfer occurs on a rising edge where valid and ready are both high; each transfer is exactly one write.
REQ-016 a_ready and b_ready are combinational from valid inputs, wr_stall and arbitration state; at most one of them is high in any cycle.
REQ-017 While wr_stall is 1, both ready outputs are 0 and no transfer occurs.
REQ-018 With wr_stall 0 and exactly one valid high, that requester gets ready = 1.
REQ-019 With wr_stall 0, both valid, MODE 0: ready goes to the requester not in last_grant; MODE 1: ready goes to A.
REQ-020 last_grant is a 1-bit register updated to the granted requester on every transfer; unchanged otherwise.
REQ-021 Requesters hold reg and data stable while valid is high and ready is low; valid is not withdrawn before transfer.
REQ-022 Latency: a transfer at edge N drives regWrite = 1, writeR = reg and writeRData = data, all valid after edge N, for exactly one cycle.
REQ-023 Back-to-back transfers on consecutive edges produce regWrite high on consecutive cycles with the matching address and data each cycle.
REQ-024 A cycle with no transfer drives regWrite = 0 after the next edge; writeR and writeRData hold their last values.
REQ-025 A transfer with reg = 0 is accepted (ready high), produces regWrite = 0, and increments x0_drops.
REQ-026 wr_count increments by 1 on each cycle regWrite is 1 and wraps 16'hFFFF -> 0.
REQ-027 x0_drops saturates at 8'hFF and does not wrap.
REQ-028 Same-register requests from A and B in one cycle are serialized per REQ-019; the later grant overwrites the earlier one in the register file.
REQ-029 In MODE 0, a continuously valid requester waits at most one transfer of the other requester before being granted.

Reset
REQ-030 While rst = 0, asynchronously: regWrite = 0, writeR = 0, writeRData = 0, wr_count = 0, x0_drops = 0, last_grant = B (so A wins the first contention).
REQ-031 While rst = 0, a_ready = 0 and b_ready = 0 regardless of valids or stall.
REQ-032 Reset asserted mid-stream discards any write not yet shown on regWrite; after release, the first edge with a valid request behaves as the first transfer after reset.

Verification
REQ-033 Single A: a_valid=1, a_reg=5, a_data=32'hDEADBEEF, wr_stall=0 -> a_ready=1 that cycle; next cycle regWrite=1, writeR=5, writeRData=32'hDEADBEEF; wr_count=1.
REQ-034 Contention, MODE 0, both valid for 4 edges (A reg 1 data 32'h11, B reg 2 data 32'h22, new data each grant) -> grant order A,B,A,B; regWrite high 4 consecutive cycles.
REQ-035 MODE 1, both valid 3 edges -> A granted all 3; b_ready stays 0; B granted on the edge after a_valid drops.
REQ-036 wr_stall=1 for 3 cycles with a_valid=1 -> a_ready=0 and regWrite=0 throughout; after wr_stall=0, one transfer; a_reg and a_data unchanged while held.
REQ-037 a_reg=0, a_data=32'hFFFFFFFF -> a_ready=1, regWrite stays 0, x0_drops=1, wr_count unchanged; 300 such writes -> x0_drops=8'hFF.
REQ-038 rst driven to 0 asynchronously between edges, in the cycle after a transfer -> regWrite and counters go to 0 immediately; after rst=1 and a contended request, A wins.
